// File: rtl/aes128_round_sequencer_pkg.sv
// aes_pkg: shared FSM type, block constants and GF(2^8) helpers
// used by the iterative AES-128 round sequencer and its datapath.
package aes_pkg;

  localparam int AES_ROUNDS = 10;
  localparam int AES_BLK_W  = 128;
  localparam int AES_RC_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } aes_fsm_e;

  // element 0 is the most significant byte (bits 127:120)
  typedef logic [0:15][7:0] blk_t;
  typedef logic [AES_RC_W-1:0] rc_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // inverse as a^254 (maps 0 to 0), then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input rc_t rc);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < 16; i++) begin
      if (i < int'(rc)) r = xtime(r);
    end
    return r;
  endfunction

  function automatic blk_t sub_bytes(input blk_t x);
    blk_t y;
    for (int i = 0; i < 16; i++) begin
      y[4'(i)] = sbox(x[4'(i)]);
    end
    return y;
  endfunction

  // column-major state: byte 4*c+r sits at row r, column c
  function automatic blk_t shift_rows(input blk_t x);
    blk_t y;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        y[4'(4*c+r)] = x[4'(4*((c+r)%4)+r)];
      end
    end
    return y;
  endfunction

  function automatic blk_t mix_columns(input blk_t x);
    blk_t y;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = x[4'(4*c)];
      a1 = x[4'(4*c+1)];
      a2 = x[4'(4*c+2)];
      a3 = x[4'(4*c+3)];
      y[4'(4*c)]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      y[4'(4*c+1)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      y[4'(4*c+2)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      y[4'(4*c+3)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return y;
  endfunction

  // one step of the AES-128 key schedule
  function automatic blk_t key_step(
    input blk_t k,
    input rc_t  rc
  );
    logic [0:3][7:0] t;
    blk_t n;
    t[0] = sbox(k[13]) ^ rcon(rc);
    t[1] = sbox(k[14]);
    t[2] = sbox(k[15]);
    t[3] = sbox(k[12]);
    for (int i = 0; i < 4; i++) begin
      n[4'(i)] = k[4'(i)] ^ t[2'(i)];
    end
    for (int i = 4; i < 16; i++) begin
      n[4'(i)] = k[4'(i)] ^ n[4'(i-4)];
    end
    return n;
  endfunction

endpackage

// File: rtl/aes128_round_sequencer_if.sv
// Host-side bus of the AES-128 sequencer: request (start/ready, key,
// data, abort) and response (out_valid/out_ready, data_out, round_no).
interface aes128_round_sequencer_if;
  logic         start;
  logic         ready;
  logic [127:0] key_in;
  logic [127:0] data_in;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic [3:0]   round_no;

  modport master (
    output start, key_in, data_in, abort, out_ready,
    input  ready, out_valid, data_out, round_no
  );

  modport slave (
    input  start, key_in, data_in, abort, out_ready,
    output ready, out_valid, data_out, round_no
  );
endinterface

// File: rtl/BaytDegistir.sv
// SubBytes: S-box applied to each of the 16 state bytes.
// Ports: i_data state in, o_data substituted state.
module BaytDegistir
  import aes_pkg::*;
(
  input  blk_t i_data,
  output blk_t o_data
);
  assign o_data = sub_bytes(i_data);
endmodule

// File: rtl/aes128_final_round.sv
// Last AES round: SubBytes, ShiftRows, AddRoundKey (no MixColumns).
// Ports: i_state, i_key (round-9 key) in; o_state ciphertext out.
module aes128_final_round
  import aes_pkg::*;
(
  input  blk_t i_state,
  input  blk_t i_key,
  output blk_t o_state
);
  blk_t w_key;
  blk_t w_sb;
  blk_t w_sr;

  keygenerating u_kg (
    .i_key (i_key),
    .i_rc  (rc_t'(AES_ROUNDS)),
    .o_key (w_key)
  );

  BaytDegistir u_sb (
    .i_data (i_state),
    .o_data (w_sb)
  );

  shiftrows u_sr (
    .i_data (w_sb),
    .o_data (w_sr)
  );

  assign o_state = w_sr ^ w_key;
endmodule

// File: rtl/keygenerating.sv
// Next AES-128 round key from the current one and a round index.
// Ports: i_key current key, i_rc round index, o_key next key.
module keygenerating
  import aes_pkg::*;
(
  input  blk_t i_key,
  input  rc_t  i_rc,
  output blk_t o_key
);
  assign o_key = key_step(i_key, i_rc);
endmodule

// File: rtl/round_dokuzakadar.sv
// Full AES round (rounds 1-9) plus the matching key-schedule step.
// Ports: roundConstant, key, veri in; cikis state, anahtar_cikis key out.
module round_dokuzakadar
  import aes_pkg::*;
(
  input  rc_t  roundConstant,
  input  blk_t key,
  input  blk_t veri,
  output blk_t cikis,
  output blk_t anahtar_cikis
);
  blk_t w_sb;
  blk_t w_sr;

  keygenerating u_kg (
    .i_key (key),
    .i_rc  (roundConstant),
    .o_key (anahtar_cikis)
  );

  BaytDegistir u_sb (
    .i_data (veri),
    .o_data (w_sb)
  );

  shiftrows u_sr (
    .i_data (w_sb),
    .o_data (w_sr)
  );

  assign cikis = mix_columns(w_sr) ^ anahtar_cikis;
endmodule

// File: rtl/shiftrows.sv
// ShiftRows: row r of the column-major state rotated left by r.
// Ports: i_data state in, o_data shifted state.
module shiftrows
  import aes_pkg::*;
(
  input  blk_t i_data,
  output blk_t o_data
);
  assign o_data = shift_rows(i_data);
endmodule

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryptor: one round per cycle, ten rounds.
// Ports: clk, rst_n (async, active-low), bus (slave side of the if).
module aes128_round_sequencer
  import aes_pkg::*;
#(
  parameter int ROUNDS = AES_ROUNDS
) (
  input logic                      clk,
  input logic                      rst_n,
  aes128_round_sequencer_if.slave  bus
);

  if (ROUNDS != AES_ROUNDS) begin : g_bad_rounds
    $error("aes128_round_sequencer: ROUNDS must be 10");
  end

  aes_fsm_e r_fsm;
  aes_fsm_e w_fsm_nx;
  blk_t     r_state;
  blk_t     w_state_nx;
  blk_t     r_rkey;
  blk_t     w_rkey_nx;
  rc_t      r_rnd;
  rc_t      w_rnd_nx;
  blk_t     w_rnd_state;
  blk_t     w_rnd_key;
  blk_t     w_fin_state;
  logic     w_done;

  round_dokuzakadar u_round (
    .roundConstant (r_rnd),
    .key           (r_rkey),
    .veri          (r_state),
    .cikis         (w_rnd_state),
    .anahtar_cikis (w_rnd_key)
  );

  aes128_final_round u_final (
    .i_state (r_state),
    .i_key   (r_rkey),
    .o_state (w_fin_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_rkey  <= '0;
      r_rnd   <= '0;
    end else begin
      r_fsm   <= w_fsm_nx;
      r_state <= w_state_nx;
      r_rkey  <= w_rkey_nx;
      r_rnd   <= w_rnd_nx;
    end
  end

  always_comb begin
    w_fsm_nx   = r_fsm;
    w_state_nx = r_state;
    w_rkey_nx  = r_rkey;
    w_rnd_nx   = r_rnd;
    unique case (r_fsm)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nx = bus.data_in ^ bus.key_in;
          w_rkey_nx  = bus.key_in;
          w_rnd_nx   = 4'd1;
          w_fsm_nx   = S_ROUND;
        end
      end
      S_ROUND: begin
        // abort wins over the round advance
        if (bus.abort) begin
          w_rnd_nx = '0;
          w_fsm_nx = S_IDLE;
        end else begin
          w_state_nx = w_rnd_state;
          w_rkey_nx  = w_rnd_key;
          w_rnd_nx   = r_rnd + 4'd1;
          if (r_rnd == rc_t'(AES_ROUNDS - 1)) begin
            w_fsm_nx = S_FINAL;
          end
        end
      end
      S_FINAL: begin
        if (bus.abort) begin
          w_rnd_nx = '0;
          w_fsm_nx = S_IDLE;
        end else begin
          w_state_nx = w_fin_state;
          w_fsm_nx   = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_rnd_nx = '0;
          w_fsm_nx = S_IDLE;
        end
      end
      default: begin
        w_rnd_nx = '0;
        w_fsm_nx = S_IDLE;
      end
    endcase
  end

  assign w_done        = (r_fsm == S_DONE);
  assign bus.ready     = (r_fsm == S_IDLE);
  assign bus.out_valid = w_done;
  assign bus.data_out  = w_done ? r_state : '0;
  assign bus.round_no  = r_rnd;

endmodule
